seq_match_event_logger: RTL and testbench

//  Downstream consumer of the sequence detector's one-cycle "detected" pulse.

---
 rtl/seq_det_pkg.sv | 17 +
 rtl/seq_event_fifo.sv | 66 ++++++
 rtl/seq_match_event_logger.sv | 89 ++++++++
 tb/tb_seq_match_event_logger.sv | 291 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/seq_det_pkg.sv
// Shared types, default widths and the saturating-increment helper for the
// sequence-detector event logger.
package seq_det_pkg;

  localparam int unsigned SEQ_TS_W  = 16;
  localparam int unsigned SEQ_CNT_W = 8;

  typedef logic [SEQ_TS_W-1:0] ts_t;

  // Increment val, holding at the all-ones value of a width-bit counter.
  function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
    logic [31:0] max_v;
    max_v = (width >= 32) ? 32'hFFFF_FFFF : ((32'd1 << width) - 32'd1);
    return (val >= max_v) ? max_v : val + 32'd1;
  endfunction

endpackage

// File: rtl/seq_event_fifo.sv
// Show-ahead synchronous FIFO: the head entry is visible on rd_data whenever
// the FIFO is not empty. A push into a full FIFO is accepted only alongside a pop.
module seq_event_fifo #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             push,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             full,
  output logic             empty
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned OCC_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [OCC_W-1:0] occ_q, occ_d;
  logic             do_push;
  logic             do_pop;

  assign empty   = (occ_q == '0);
  assign full    = (occ_q == OCC_W'(DEPTH));
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    occ_d    = occ_q;
    if (clr) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      occ_d    = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      occ_d = occ_q + OCC_W'(do_push) - OCC_W'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
    end
  end

  // Storage needs no reset: entries are only observable while occupancy covers them.
  always_ff @(posedge clk) begin
    if (do_push && !clr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/seq_match_event_logger.sv
// Timestamps detector match pulses with a free-running cycle counter, queues the
// stamps for valid/ready readout, and tracks match/drop counts plus sticky overflow.
module seq_match_event_logger
  import seq_det_pkg::*;
#(
  parameter int unsigned TS_W  = SEQ_TS_W,
  parameter int unsigned DEPTH = 4,
  parameter int unsigned CNT_W = SEQ_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             detected,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] match_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             overflow
);

  logic [TS_W-1:0]  ts_q, ts_d;
  logic [CNT_W-1:0] match_q, match_d;
  logic [CNT_W-1:0] drop_q, drop_d;
  logic             ovf_q, ovf_d;
  logic [TS_W-1:0]  head_ts;
  logic             fifo_full;
  logic             fifo_empty;
  logic             drop;

  seq_event_fifo #(
    .WIDTH (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .clr     (clr),
    .push    (detected),
    .wr_data (ts_q),
    .pop     (evt_ready),
    .rd_data (head_ts),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  // A full FIFO still takes a stamp when the head leaves in the same cycle.
  assign drop = detected & fifo_full & ~evt_ready;

  always_comb begin
    ts_d    = ts_q;
    match_d = match_q;
    drop_d  = drop_q;
    ovf_d   = ovf_q;
    if (clr) begin
      ts_d    = '0;
      match_d = '0;
      drop_d  = '0;
      ovf_d   = 1'b0;
    end else begin
      ts_d = ts_q + TS_W'(1);
      if (detected) match_d = CNT_W'(sat_inc(32'(match_q), CNT_W));
      if (drop) begin
        drop_d = CNT_W'(sat_inc(32'(drop_q), CNT_W));
        ovf_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ts_q    <= '0;
      match_q <= '0;
      drop_q  <= '0;
      ovf_q   <= 1'b0;
    end else begin
      ts_q    <= ts_d;
      match_q <= match_d;
      drop_q  <= drop_d;
      ovf_q   <= ovf_d;
    end
  end

  assign evt_valid   = ~fifo_empty;
  assign evt_ts      = fifo_empty ? '0 : head_ts;
  assign match_count = match_q;
  assign drop_count  = drop_q;
  assign overflow    = ovf_q;

endmodule

// File: tb/tb_seq_match_event_logger.sv
// Self-checking bench: a default-width logger and a narrow (TS_W=4, CNT_W=3)
// logger checked against a queue-based reference model.
module tb_seq_match_event_logger;
  import seq_det_pkg::*;

  logic clk = 1'b0;
  logic reset, clr, det, rdy;
  logic s_clr, s_det, s_rdy;

  logic        b_valid, b_ovf;
  ts_t         b_ts;
  logic [7:0]  b_mc, b_dc;
  logic        s_valid, s_ovf;
  logic [3:0]  s_ts;
  logic [2:0]  s_mc, s_dc;

  logic [33:0] got_big;
  logic [11:0] got_small;
  assign got_big   = {b_valid, b_ts, b_mc, b_dc, b_ovf};
  assign got_small = {s_valid, s_ts, s_mc, s_dc, s_ovf};

  int errors = 0;
  int checks = 0;

  // Reference model: index 0 = default DUT, 1 = narrow DUT.
  int m_ts[2], m_mc[2], m_dc[2];
  bit m_ovf[2];
  int mq[2][$];
  int m_tsmod[2] = '{65536, 16};
  int m_cmax[2]  = '{255, 7};

  seq_match_event_logger u_big (
    .clk(clk), .reset(reset), .clr(clr), .detected(det), .evt_ready(rdy),
    .evt_valid(b_valid), .evt_ts(b_ts), .match_count(b_mc), .drop_count(b_dc),
    .overflow(b_ovf)
  );

  seq_match_event_logger #(.TS_W(4), .DEPTH(4), .CNT_W(3)) u_small (
    .clk(clk), .reset(reset), .clr(s_clr), .detected(s_det), .evt_ready(s_rdy),
    .evt_valid(s_valid), .evt_ts(s_ts), .match_count(s_mc), .drop_count(s_dc),
    .overflow(s_ovf)
  );

  always #5 clk = ~clk;

  task automatic model_reset(input int i);
    m_ts[i] = 0; m_mc[i] = 0; m_dc[i] = 0; m_ovf[i] = 0;
    mq[i].delete();
  endtask

  task automatic model_edge();
    bit c[2], d[2], r[2];
    c = '{clr, s_clr}; d = '{det, s_det}; r = '{rdy, s_rdy};
    for (int i = 0; i < 2; i++) begin
      if (reset || c[i]) begin
        model_reset(i);
      end else begin
        if (r[i] && mq[i].size() > 0) void'(mq[i].pop_front());
        if (d[i]) begin
          if (m_mc[i] < m_cmax[i]) m_mc[i]++;
          if (mq[i].size() < 4) mq[i].push_back(m_ts[i]);
          else begin
            if (m_dc[i] < m_cmax[i]) m_dc[i]++;
            m_ovf[i] = 1;
          end
        end
        m_ts[i] = (m_ts[i] + 1) % m_tsmod[i];
      end
    end
  endtask

  function automatic logic [33:0] exp_big();
    logic v;
    v = mq[0].size() > 0;
    return {v, v ? 16'(mq[0][0]) : 16'd0, 8'(m_mc[0]), 8'(m_dc[0]), 1'(m_ovf[0])};
  endfunction

  function automatic logic [11:0] exp_small();
    logic v;
    v = mq[1].size() > 0;
    return {v, v ? 4'(mq[1][0]) : 4'd0, 3'(m_mc[1]), 3'(m_dc[1]), 1'(m_ovf[1])};
  endfunction

  task automatic tick();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if (got_big !== 34'd0) begin errors++; $display("FAIL reset_big got=%h exp=0", got_big); end
    checks++;
    if (got_small !== 12'd0) begin errors++; $display("FAIL reset_small got=%h exp=0", got_small); end
    reset = 1'b0;
    det = 1'b1;
    tick();
    det = 1'b0;
    checks++;
    if (got_big !== exp_big() || b_ts !== 16'd0 || b_valid !== 1'b1) begin
      errors++; $display("FAIL first_stamp got=%h exp=%h", got_big, exp_big());
    end
    rdy = 1'b1;
    tick();
    rdy = 1'b0;
    checks++;
    if (b_valid !== 1'b0) begin errors++; $display("FAIL first_pop valid=%b exp=0", b_valid); end
  endtask

  task automatic test_single_match();
    clr = 1'b1; tick(); clr = 1'b0;
    repeat (5) tick();
    det = 1'b1; rdy = 1'b1;
    tick();
    det = 1'b0;
    checks++;
    if (got_big !== exp_big() || b_valid !== 1'b1 || b_ts !== 16'd5 || b_mc !== 8'd1 || b_dc !== 8'd0) begin
      errors++; $display("FAIL single_match got=%h exp=%h", got_big, exp_big());
    end
    tick();
    rdy = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || got_big !== exp_big()) begin
      errors++; $display("FAIL single_match_pop got=%h exp=%h", got_big, exp_big());
    end
  endtask

  task automatic test_overflow();
    int exp_ts[4] = '{2, 5, 8, 11};
    clr = 1'b1; tick(); clr = 1'b0;
    rdy = 1'b0;
    for (int t = 0; t <= 16; t++) begin
      det = (t == 2 || t == 5 || t == 8 || t == 11 || t == 14);
      tick();
    end
    det = 1'b0;
    checks++;
    if (got_big !== exp_big() || b_dc !== 8'd1 || b_ovf !== 1'b1 || b_mc !== 8'd5) begin
      errors++; $display("FAIL overflow_counts got=%h exp=%h", got_big, exp_big());
    end
    rdy = 1'b1;
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (b_valid !== 1'b1 || b_ts !== 16'(exp_ts[k])) begin
        errors++; $display("FAIL overflow_drain%0d valid=%b ts=%0d exp_ts=%0d", k, b_valid, b_ts, exp_ts[k]);
      end
      tick();
    end
    rdy = 1'b0;
    checks++;
    if (b_valid !== 1'b0 || got_big !== exp_big()) begin
      errors++; $display("FAIL overflow_empty got=%h exp=%h", got_big, exp_big());
    end
  endtask

  task automatic test_full_push_pop();
    int pops = 0;
    clr = 1'b1; tick(); clr = 1'b0;
    rdy = 1'b0; det = 1'b1;
    repeat (4) tick();
    checks++;
    if (got_big !== exp_big() || b_ts !== 16'd0) begin
      errors++; $display("FAIL full_fill got=%h exp=%h", got_big, exp_big());
    end
    rdy = 1'b1;
    tick();
    det = 1'b0;
    checks++;
    if (got_big !== exp_big() || b_dc !== 8'd0 || b_ts !== 16'd1 || b_mc !== 8'd5) begin
      errors++; $display("FAIL full_push_pop got=%h exp=%h", got_big, exp_big());
    end
    while (b_valid && pops < 8) begin
      checks++;
      if (b_ts !== 16'(pops + 1)) begin
        errors++; $display("FAIL full_drain%0d ts=%0d exp=%0d", pops, b_ts, pops + 1);
      end
      tick();
      pops++;
    end
    rdy = 1'b0;
    checks++;
    if (pops != 4) begin errors++; $display("FAIL full_occupancy pops=%0d exp=4", pops); end
  endtask

  task automatic test_wrap_saturation();
    s_clr = 1'b1; tick(); s_clr = 1'b0;
    repeat (15) tick();
    s_det = 1'b1;
    repeat (2) tick();
    s_det = 1'b0;
    checks++;
    if (got_small !== exp_small() || s_ts !== 4'd15) begin
      errors++; $display("FAIL wrap_head got=%h exp=%h", got_small, exp_small());
    end
    s_rdy = 1'b1;
    tick();
    checks++;
    if (got_small !== exp_small() || s_valid !== 1'b1 || s_ts !== 4'd0) begin
      errors++; $display("FAIL wrap_second got=%h exp=%h", got_small, exp_small());
    end
    tick();
    s_rdy = 1'b0;
    s_det = 1'b1;
    repeat (7) tick();
    s_det = 1'b0;
    checks++;
    if (got_small !== exp_small() || s_mc !== 3'd7 || s_dc !== 3'd3 || s_ovf !== 1'b1) begin
      errors++; $display("FAIL saturation got=%h exp=%h", got_small, exp_small());
    end
  endtask

  task automatic test_clr_reset();
    clr = 1'b1; tick(); clr = 1'b0;
    det = 1'b1; repeat (3) tick(); det = 1'b0;
    rdy = 1'b1; tick();
    checks++;
    if (got_big !== exp_big() || b_valid !== 1'b1) begin
      errors++; $display("FAIL middrain got=%h exp=%h", got_big, exp_big());
    end
    clr = 1'b1; det = 1'b1;
    tick();
    clr = 1'b0; det = 1'b0; rdy = 1'b0;
    checks++;
    if (got_big !== 34'd0 || got_big !== exp_big()) begin
      errors++; $display("FAIL clr_state got=%h exp=0", got_big);
    end
    det = 1'b1; tick(); det = 1'b0;
    checks++;
    if (b_valid !== 1'b1 || b_ts !== 16'd0) begin
      errors++; $display("FAIL clr_restamp valid=%b ts=%0d exp_ts=0", b_valid, b_ts);
    end
    det = 1'b1; repeat (3) tick(); det = 1'b0;
    rdy = 1'b1; tick(); rdy = 1'b0;
    #2 reset = 1'b1;
    model_reset(0); model_reset(1);
    #1;
    checks++;
    if (got_big !== 34'd0 || got_small !== 12'd0) begin
      errors++; $display("FAIL async_reset big=%h small=%h exp=0", got_big, got_small);
    end
    tick();
    reset = 1'b0;
    det = 1'b1; tick(); det = 1'b0;
    checks++;
    if (got_big !== exp_big() || b_valid !== 1'b1 || b_ts !== 16'd0) begin
      errors++; $display("FAIL reset_restamp got=%h exp=%h", got_big, exp_big());
    end
  endtask

  task automatic test_random();
    int dprob;
    for (int n = 0; n < 600; n++) begin
      dprob = (n / 150) + 1;
      det   = ($urandom_range(0, 4) < dprob);
      rdy   = ($urandom_range(0, 2) != 0);
      clr   = ($urandom_range(0, 99) == 0);
      s_det = ($urandom_range(0, 4) < dprob);
      s_rdy = ($urandom_range(0, 3) == 0);
      s_clr = ($urandom_range(0, 149) == 0);
      tick();
      checks++;
      if (got_big !== exp_big()) begin
        errors++; $display("FAIL random_big n=%0d got=%h exp=%h", n, got_big, exp_big());
      end
      checks++;
      if (got_small !== exp_small()) begin
        errors++; $display("FAIL random_small n=%0d got=%h exp=%h", n, got_small, exp_small());
      end
    end
    det = 1'b0; rdy = 1'b0; clr = 1'b0;
    s_det = 1'b0; s_rdy = 1'b0; s_clr = 1'b0;
  endtask

  initial begin
    reset = 1'b1; clr = 1'b0; det = 1'b0; rdy = 1'b0;
    s_clr = 1'b0; s_det = 1'b0; s_rdy = 1'b0;
    model_reset(0); model_reset(1);
    test_reset();
    test_single_match();
    test_overflow();
    test_full_push_pop();
    test_wrap_saturation();
    test_clr_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
